// File: rtl/simple_alu_pipe_if.sv
// simple_alu_pipe_if
//   Issue/writeback bundle for the pipelined execute ALU, plus the shared
//   opcode and flag-width encodings used by the ALU and anything that
//   drives it.
//   Issue side    : flush_i, valid_i, data1_i, data2_i, immd_i, opcode_i,
//                   tag_i into the ALU; ready_o back to issue.
//   Writeback side: valid_o, result_o, flags_o, tag_o out of the ALU;
//                   ready_i back from writeback.
//   modport slave is the ALU, modport master is the issue/writeback side.

`ifndef SIMPLE_ALU_PIPE_DEFS
`define SIMPLE_ALU_PIPE_DEFS
`define SIZE_OPCODE_I   6
`define EXECUTION_FLAGS 6
`define ADD    6'd0
`define ADDU   6'd1
`define SUB    6'd2
`define SUBU   6'd3
`define ADDI   6'd4
`define ADDIU  6'd5
`define SLT    6'd6
`define SLTU   6'd7
`define SLTI   6'd8
`define SLTIU  6'd9
`define AND    6'd10
`define OR     6'd11
`define XOR    6'd12
`define NOR    6'd13
`define ANDI   6'd14
`define ORI    6'd15
`define XORI   6'd16
`define LUI    6'd17
`define SLL    6'd18
`define SRL    6'd19
`define SRA    6'd20
`define SLLV   6'd21
`define SRLV   6'd22
`define SRAV   6'd23
`define MFHI   6'd24
`define MTHI   6'd25
`define MFLO   6'd26
`define MTLO   6'd27
`define NOP    6'd28
`endif

interface simple_alu_pipe_if #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int TAG_W  = 7,
    parameter int OPC_W  = `SIZE_OPCODE_I,
    parameter int FLAG_W = `EXECUTION_FLAGS
);
    logic              flush_i;
    logic              valid_i;
    logic              ready_o;
    logic [DATA_W-1:0] data1_i;
    logic [DATA_W-1:0] data2_i;
    logic [IMM_W-1:0]  immd_i;
    logic [OPC_W-1:0]  opcode_i;
    logic [TAG_W-1:0]  tag_i;
    logic              valid_o;
    logic              ready_i;
    logic [DATA_W-1:0] result_o;
    logic [FLAG_W-1:0] flags_o;
    logic [TAG_W-1:0]  tag_o;

    modport master (
        output flush_i, valid_i, data1_i, data2_i, immd_i, opcode_i, tag_i, ready_i,
        input  ready_o, valid_o, result_o, flags_o, tag_o
    );

    modport slave (
        input  flush_i, valid_i, data1_i, data2_i, immd_i, opcode_i, tag_i, ready_i,
        output ready_o, valid_o, result_o, flags_o, tag_o
    );
endinterface

// File: rtl/simple_alu_pipe.sv
// simple_alu_pipe
//   Pipelined integer ALU for the execute stage. One op per cycle enters
//   through a valid/ready handshake, is decoded, executed and leaves after
//   PIPE_DEPTH registered stages together with its issue tag and flags.
//   Every stage is elastic, so writeback backpressure stalls the pipe
//   without bubbles; flush_i kills everything in flight at the next edge.
// Ports
//   clk    : clock, all state on the rising edge
//   reset  : asynchronous, active-high reset
//   alu    : simple_alu_pipe_if.slave (issue in, result out, flush)
// Flags layout: {1'b0, wr_dest, 1'b0, executed, exception, mispredict}

module simple_alu_pipe #(
    parameter int DATA_W     = 32,
    parameter int IMM_W      = 16,
    parameter int TAG_W      = 7,
    parameter int PIPE_DEPTH = 2,
    parameter int OPC_W      = `SIZE_OPCODE_I,
    parameter int FLAG_W     = `EXECUTION_FLAGS
) (
    input logic             clk,
    input logic             reset,
    simple_alu_pipe_if.slave alu
);

    localparam int SH_W = $clog2(DATA_W);

    // Operation classes after decode: immediate forms collapse onto their
    // register forms once the second operand has been selected.
    typedef enum logic [3:0] {
        C_ADD, C_ADDU, C_SUB, C_SUBU, C_SLT, C_SLTU,
        C_AND, C_OR, C_XOR, C_NOR, C_SLL, C_SRL, C_SRA,
        C_PASS, C_NOP, C_UNDEF
    } op_class_e;

    typedef struct packed {
        op_class_e         cls;
        logic [DATA_W-1:0] a;      // data1
        logic [DATA_W-1:0] b;      // second operand / shifted value / pass value
        logic [SH_W-1:0]   shamt;
    } dec_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [FLAG_W-1:0] flags;
    } exe_t;

    // Parameter sanity: illegal configurations fail elaboration.
    generate
        if (IMM_W >= DATA_W) begin : g_bad_imm
            $error("simple_alu_pipe: IMM_W must be smaller than DATA_W");
        end
        if (IMM_W < SH_W) begin : g_bad_sh
            $error("simple_alu_pipe: IMM_W too small to hold a shift amount");
        end
        if (FLAG_W < 6) begin : g_bad_flags
            $error("simple_alu_pipe: FLAG_W must be at least 6");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [OPC_W-1:0]  opc;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] imm_lui;
    dec_t              dec;

    assign opc      = alu.opcode_i;
    assign imm_sext = {{(DATA_W-IMM_W){alu.immd_i[IMM_W-1]}}, alu.immd_i};
    assign imm_zext = {{(DATA_W-IMM_W){1'b0}}, alu.immd_i};
    assign imm_lui  = {alu.immd_i, {(DATA_W-IMM_W){1'b0}}};

    always_comb begin
        dec.cls   = C_UNDEF;
        dec.a     = alu.data1_i;
        dec.b     = alu.data2_i;
        dec.shamt = alu.immd_i[SH_W-1:0];
        case (opc)
            `ADD:   dec.cls = C_ADD;
            `ADDU:  dec.cls = C_ADDU;
            `SUB:   dec.cls = C_SUB;
            `SUBU:  dec.cls = C_SUBU;
            `ADDI:  begin dec.cls = C_ADD;  dec.b = imm_sext; end
            `ADDIU: begin dec.cls = C_ADDU; dec.b = imm_sext; end
            `SLT:   dec.cls = C_SLT;
            `SLTU:  dec.cls = C_SLTU;
            `SLTI:  begin dec.cls = C_SLT;  dec.b = imm_sext; end
            `SLTIU: begin dec.cls = C_SLTU; dec.b = imm_zext; end
            `AND:   dec.cls = C_AND;
            `OR:    dec.cls = C_OR;
            `XOR:   dec.cls = C_XOR;
            `NOR:   dec.cls = C_NOR;
            `ANDI:  begin dec.cls = C_AND;  dec.b = imm_zext; end
            `ORI:   begin dec.cls = C_OR;   dec.b = imm_zext; end
            `XORI:  begin dec.cls = C_XOR;  dec.b = imm_zext; end
            `LUI:   begin dec.cls = C_PASS; dec.b = imm_lui;  end
            `SLL:   dec.cls = C_SLL;
            `SRL:   dec.cls = C_SRL;
            `SRA:   dec.cls = C_SRA;
            `SLLV:  begin dec.cls = C_SLL; dec.shamt = alu.data1_i[SH_W-1:0]; end
            `SRLV:  begin dec.cls = C_SRL; dec.shamt = alu.data1_i[SH_W-1:0]; end
            `SRAV:  begin dec.cls = C_SRA; dec.shamt = alu.data1_i[SH_W-1:0]; end
            // HI/LO moves just forward rs.
            `MFHI, `MTHI, `MFLO, `MTLO: begin dec.cls = C_PASS; dec.b = alu.data1_i; end
            `NOP:   dec.cls = C_NOP;
            default: dec.cls = C_UNDEF;
        endcase
    end

    // ------------------------------------------------------------------
    // Execute: pure function of a decoded op, used by either pipe shape.
    // ------------------------------------------------------------------
    function automatic exe_t execute(input dec_t d);
        exe_t              o;
        logic [DATA_W-1:0] r;
        logic              wr;
        logic              ex;
        logic              ov;
        r  = '0;
        wr = 1'b1;
        ex = 1'b1;
        ov = 1'b0;
        case (d.cls)
            C_ADD: begin
                r  = d.a + d.b;
                ov = (d.a[DATA_W-1] == d.b[DATA_W-1]) && (r[DATA_W-1] != d.a[DATA_W-1]);
            end
            C_ADDU: r = d.a + d.b;
            C_SUB: begin
                r  = d.a - d.b;
                ov = (d.a[DATA_W-1] != d.b[DATA_W-1]) && (r[DATA_W-1] != d.a[DATA_W-1]);
            end
            C_SUBU: r = d.a - d.b;
            C_SLT:  r = {{(DATA_W-1){1'b0}}, ($signed(d.a) < $signed(d.b))};
            C_SLTU: r = {{(DATA_W-1){1'b0}}, (d.a < d.b)};
            C_AND:  r = d.a & d.b;
            C_OR:   r = d.a | d.b;
            C_XOR:  r = d.a ^ d.b;
            C_NOR:  r = ~(d.a | d.b);
            C_SLL:  r = d.b << d.shamt;
            C_SRL:  r = d.b >> d.shamt;
            C_SRA:  r = $unsigned($signed(d.b) >>> d.shamt);
            C_PASS: r = d.b;
            C_NOP:  wr = 1'b0;
            default: begin
                wr = 1'b0;
                ex = 1'b0;
            end
        endcase
        o.result   = r;
        o.flags    = '0;
        o.flags[4] = wr;
        o.flags[2] = ex;
        o.flags[1] = ov;
        return o;
    endfunction

    // ------------------------------------------------------------------
    // Pipeline
    // ------------------------------------------------------------------
    generate
        if (PIPE_DEPTH == 2) begin : g_two
            logic             s1_valid;
            logic             s2_valid;
            dec_t             s1_q;
            logic [TAG_W-1:0] s1_tag;
            exe_t             s2_q;
            logic [TAG_W-1:0] s2_tag;
            exe_t             s2_d;
            logic             s1_load;
            logic             s2_load;

            // Stage 2 can take new data when empty or draining this cycle;
            // stage 1 likewise when empty or moving into stage 2.
            assign s2_load = !s2_valid || alu.ready_i;
            assign s1_load = !s1_valid || s2_load;
            assign s2_d    = execute(s1_q);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s1_valid <= 1'b0;
                    s2_valid <= 1'b0;
                    s1_q     <= '0;
                    s1_tag   <= '0;
                    s2_q     <= '0;
                    s2_tag   <= '0;
                end else begin
                    if (alu.flush_i) begin
                        s1_valid <= 1'b0;
                        s2_valid <= 1'b0;
                    end else begin
                        if (s1_load) s1_valid <= alu.valid_i;
                        if (s2_load) s2_valid <= s1_valid;
                    end
                    // Data only moves with a valid op, so stalled stages stay bit-stable.
                    if (s1_load && alu.valid_i) begin
                        s1_q   <= dec;
                        s1_tag <= alu.tag_i;
                    end
                    if (s2_load && s1_valid) begin
                        s2_q   <= s2_d;
                        s2_tag <= s1_tag;
                    end
                end
            end

            assign alu.ready_o  = s1_load;
            assign alu.valid_o  = s2_valid;
            assign alu.result_o = s2_q.result;
            assign alu.flags_o  = s2_q.flags;
            assign alu.tag_o    = s2_tag;
        end else if (PIPE_DEPTH == 1) begin : g_one
            logic             s_valid;
            exe_t             s_q;
            logic [TAG_W-1:0] s_tag;
            exe_t             s_d;
            logic             s_load;

            assign s_load = !s_valid || alu.ready_i;
            assign s_d    = execute(dec);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s_valid <= 1'b0;
                    s_q     <= '0;
                    s_tag   <= '0;
                end else begin
                    if (alu.flush_i) s_valid <= 1'b0;
                    else if (s_load) s_valid <= alu.valid_i;
                    if (s_load && alu.valid_i) begin
                        s_q   <= s_d;
                        s_tag <= alu.tag_i;
                    end
                end
            end

            assign alu.ready_o  = s_load;
            assign alu.valid_o  = s_valid;
            assign alu.result_o = s_q.result;
            assign alu.flags_o  = s_q.flags;
            assign alu.tag_o    = s_tag;
        end else begin : g_bad_depth
            $error("simple_alu_pipe: PIPE_DEPTH must be 1 or 2");
        end
    endgenerate

endmodule
